instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the 32-bit datapath: fetch, decode, execute, memory, writeback.
//  Owns PC and IR; decodes fields and drives ALU op select, operand mux, writeback mux and write enables.
//  Sits between instruction memory, data memory, register file and ALU; one instruction in flight at a time.
// PARAMETERS
//  ADDR_W      16   PC and data-address width (bits)
//  PC_RESET    0    PC value after reset and on start
//  TIMEOUT     255  max cycles waiting for imem_ack/dmem_ack before error; 8-bit counter
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse in IDLE: load PC_RESET, begin FETCH
//  imem_req     out  1       instruction read request, held until ack
//  imem_addr    out  ADDR_W  = pc
//  imem_ack     in   1       rdata valid this cycle
//  imem_rdata   in   32      instruction word
//  dmem_req     out  1       data access request, held until ack
//  dmem_we      out  1       1 = store (we2), 0 = load
//  dmem_ack     in   1       access complete; load data valid on datapath this cycle
//  rs,rd,rt     out  6 each  IR[6:1], IR[12:7], IR[22:17]
//  imm9         out  9       IR[31:23]; imm15 out 15 IR[31:17]
//  alu_op_sel   out  4       IR[16:13] (funct)
//  ms1          out  1       IR[0]: 0 = R-type (rt operand), 1 = I-type (imm15 operand)
//  ms2          out  1       writeback mux: 0 = ALU result, 1 = load data
//  we1          out  1       register-file write enable, 1-cycle pulse in WB
//  busy         out  1       high in every state except IDLE/HALTED/ERROR
//  halted       out  1       HALT executed; illegal out 1 sticky unknown-funct flag; error out 1 timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=PC_RESET, IR=0, all outputs 0, counter=0, flags cleared.
//  Funct map: 0x0-0x6 ALU ops (writeback), 0x7 LOAD, 0x8 STORE, 0xF HALT, 0x9-0xE illegal (NOP, set illegal).
//  IDLE   : start -> FETCH, pc=PC_RESET. start ignored in every other state.
//  FETCH  : imem_req=1. On imem_ack: IR<=imem_rdata -> DECODE. Ack in first FETCH cycle allowed.
//  DECODE : 1 cycle; fields/ms1/alu_op_sel valid from here until next FETCH. HALT -> HALTED, pc unchanged.
//  EXEC   : 1 cycle. ALU -> WB; LOAD/STORE -> MEM; illegal -> pc+1, FETCH (no write).
//  MEM    : dmem_req=1, dmem_we=(STORE). On ack: LOAD -> WB (ms2=1); STORE -> pc+1, FETCH.
//  WB     : we1=1 for exactly 1 cycle, ms2 as per op; pc<=pc+1 (wraps modulo 2^ADDR_W) -> FETCH.
//  HALTED : halted=1; start -> FETCH with pc=PC_RESET, halted and illegal cleared.
//  ERROR  : counter in FETCH/MEM reaches TIMEOUT without ack -> ERROR, error=1, reqs drop. Exit only by reset.
//  Counter clears on every state entry; ack on the TIMEOUT cycle wins over error.
//  Latency with same-cycle ack: ALU op 4 cycles (F,D,E,WB), LOAD 5, STORE 4, illegal 3.
//  rd==0 still written (no hardwired zero in this block). Ack outside FETCH/MEM ignored.
//  Async reset mid-access drops req immediately; memory side must tolerate abandoned request.
// STRUCTURE
//  Package seq_pkg: state_t enum, funct constants (FN_LOAD, FN_STORE, FN_HALT, FN_ALU_MAX),
//  field bit-position localparams, TYPE_R/TYPE_I.
//  One sub-module: instr_field_decode (combinational IR -> fields, op class, illegal).
//  Top: FSM, PC, IR, timeout counter, output registers.
// TESTING
//  reset then start, imem returns 0x0000_0000 (ADD, R) with ack same cycle -> we1 pulse at cycle 4, pc=1.
//  LOAD IR=funct 0x7, type 1, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, then WB ms2=1, we1=1.
//  STORE funct 0x8 -> dmem_we=1 during MEM, no we1 pulse, pc+1.
//  funct 0xA -> illegal=1, no writes; next fetch at pc+1; HALT 0xF -> halted=1, pc frozen, busy=0.
//  imem_ack never asserted -> error=1 after TIMEOUT=255 cycles, imem_req=0; rst_n low -> all outputs 0.
//  pc=0xFFFF (ADDR_W=16) executes ADD -> pc wraps to 0x0000; rst_n pulse mid-MEM -> IDLE, dmem_req=0 at once.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer.
package seq_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 6;
  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned IMM9_W  = 9;
  localparam int unsigned IMM15_W = 15;
  localparam int unsigned CNT_W   = 8;

  // Instruction field positions (LSB of each field)
  localparam int unsigned TYPE_LSB  = 0;
  localparam int unsigned RS_LSB    = 1;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned FUNCT_LSB = 13;
  localparam int unsigned RT_LSB    = 17;
  localparam int unsigned IMM15_LSB = 17;
  localparam int unsigned IMM9_LSB  = 23;

  localparam logic [FUNCT_W-1:0] FN_ALU_MAX = 4'h6;
  localparam logic [FUNCT_W-1:0] FN_LOAD    = 4'h7;
  localparam logic [FUNCT_W-1:0] FN_STORE   = 4'h8;
  localparam logic [FUNCT_W-1:0] FN_HALT    = 4'hF;

  localparam logic TYPE_R = 1'b0;
  localparam logic TYPE_I = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_HALT,
    OP_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rt;
    logic [IMM9_W-1:0]  imm9;
    logic [IMM15_W-1:0] imm15;
    logic [FUNCT_W-1:0] funct;
    logic               ms1;
  } fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Splits the instruction register into operand fields and classifies the funct.
module instr_field_decode
  import seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output fields_t            fields_c,
  output op_class_t          op_class_c
);

  logic [FUNCT_W-1:0] funct;

  // Field extraction and op classification; unknown functs fall through to illegal
  always_comb begin
    funct            = ir[FUNCT_LSB +: FUNCT_W];
    fields_c.rs      = ir[RS_LSB +: REG_W];
    fields_c.rd      = ir[RD_LSB +: REG_W];
    fields_c.rt      = ir[RT_LSB +: REG_W];
    fields_c.imm9    = ir[IMM9_LSB +: IMM9_W];
    fields_c.imm15   = ir[IMM15_LSB +: IMM15_W];
    fields_c.funct   = funct;
    fields_c.ms1     = ir[TYPE_LSB];
    op_class_c       = OP_ILLEGAL;
    if (funct <= FN_ALU_MAX)    op_class_c = OP_ALU;
    else if (funct == FN_LOAD)  op_class_c = OP_LOAD;
    else if (funct == FN_STORE) op_class_c = OP_STORE;
    else if (funct == FN_HALT)  op_class_c = OP_HALT;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM owning PC and IR.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rt,
  output logic [IMM9_W-1:0]   imm9,
  output logic [IMM15_W-1:0]  imm15,
  output logic [FUNCT_W-1:0]  alu_op_sel,
  output logic                ms1,
  output logic                ms2,
  output logic                we1,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                error
);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] ir, ir_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               illegal_n;
  fields_t            fields_c;
  op_class_t          op_class_c;

  instr_field_decode u_decode (
    .ir         (ir),
    .fields_c   (fields_c),
    .op_class_c (op_class_c)
  );

  // Fields are direct slices of the IR register, stable from DECODE until the next fetch
  assign imem_addr  = pc;
  assign rs         = fields_c.rs;
  assign rd         = fields_c.rd;
  assign rt         = fields_c.rt;
  assign imm9       = fields_c.imm9;
  assign imm15      = fields_c.imm15;
  assign alu_op_sel = fields_c.funct;
  assign ms1        = fields_c.ms1;

  // Next-state, PC/IR update and wait counter; counter is zero in every non-waiting state
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ir_n      = ir;
    cnt_n     = '0;
    illegal_n = illegal;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = PC_RESET;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_n    = imem_rdata;
          state_n = S_DECODE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_n = S_ERROR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_n = (op_class_c == OP_HALT) ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        case (op_class_c)
          OP_ALU:             state_n = S_WB;
          OP_LOAD, OP_STORE:  state_n = S_MEM;
          default: begin
            illegal_n = 1'b1;
            pc_n      = pc + ADDR_W'(1);
            state_n   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_class_c == OP_LOAD) begin
            state_n = S_WB;
          end else begin
            pc_n    = pc + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_n = S_ERROR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_n    = pc + ADDR_W'(1);
        state_n = S_FETCH;
      end
      S_HALTED: begin
        if (start) begin
          pc_n      = PC_RESET;
          illegal_n = 1'b0;
          state_n   = S_FETCH;
        end
      end
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath registers and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= PC_RESET;
      ir       <= '0;
      cnt      <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      we1      <= 1'b0;
      ms2      <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      cnt      <= cnt_n;
      imem_req <= (state_n == S_FETCH);
      dmem_req <= (state_n == S_MEM);
      dmem_we  <= (state_n == S_MEM) && (op_class_c == OP_STORE);
      we1      <= (state_n == S_WB);
      ms2      <= (state_n == S_WB) && (op_class_c == OP_LOAD);
      busy     <= !((state_n == S_IDLE) || (state_n == S_HALTED) || (state_n == S_ERROR));
      halted   <= (state_n == S_HALTED);
      illegal  <= illegal_n;
      error    <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, dmem_req, dmem_we, ms1, ms2, we1, busy, halted, illegal, error;
  logic [15:0] imem_addr;
  logic [5:0]  rs, rd, rt;
  logic [8:0]  imm9;
  logic [14:0] imm15;
  logic [3:0]  alu_op_sel;

  logic        w_imem_req, w_dmem_req, w_dmem_we, w_ms1, w_ms2, w_we1, w_busy, w_halted, w_illegal, w_error;
  logic [15:0] w_imem_addr;
  logic [5:0]  w_rs, w_rd, w_rt;
  logic [8:0]  w_imm9;
  logic [14:0] w_imm15;
  logic [3:0]  w_alu_op_sel;

  instr_sequencer #(.ADDR_W(16), .PC_RESET(16'h0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rs(rs), .rd(rd), .rt(rt), .imm9(imm9), .imm15(imm15), .alu_op_sel(alu_op_sel),
    .ms1(ms1), .ms2(ms2), .we1(we1), .busy(busy), .halted(halted), .illegal(illegal), .error(error)
  );

  // Second instance starting at the top of the address space to observe PC wrap
  instr_sequencer #(.ADDR_W(16), .PC_RESET(16'hFFFF), .TIMEOUT(TMO)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
    .rs(w_rs), .rd(w_rd), .rt(w_rt), .imm9(w_imm9), .imm15(w_imm15), .alu_op_sel(w_alu_op_sel),
    .ms1(w_ms1), .ms2(w_ms2), .we1(w_we1), .busy(w_busy), .halted(w_halted), .illegal(w_illegal), .error(w_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cycles;
    logic [1:0]  we_cnt;
    logic        ms2_at_we;
    logic        dwe_seen;
    logic [7:0]  dreq_cyc;
    logic [15:0] pc;
    logic        illegal;
    logic        halted;
    logic [46:0] flds;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc;
  logic        exp_ill;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] fn, input logic typ, input logic [5:0] a,
                                      input logic [5:0] d, input logic [5:0] t, input logic [8:0] im);
    return {im, t, fn, d, a, typ};
  endfunction

  // Reference behaviour of one instruction from the current PC
  function automatic exp_t model(input logic [31:0] ins, input int dly);
    exp_t e;
    logic [3:0] fn;
    fn = ins[16:13];
    e = '0;
    e.flds = {ins[6:1], ins[12:7], ins[22:17], ins[31:23], ins[31:17], fn, ins[0]};
    e.pc = exp_pc + 16'd1;
    e.illegal = exp_ill;
    if (fn <= 4'h6) begin
      e.cycles = 8'd4; e.we_cnt = 2'd1;
    end else if (fn == 4'h7) begin
      e.cycles = 8'(5 + dly); e.we_cnt = 2'd1; e.ms2_at_we = 1'b1; e.dreq_cyc = 8'(dly + 1);
    end else if (fn == 4'h8) begin
      e.cycles = 8'(4 + dly); e.dwe_seen = 1'b1; e.dreq_cyc = 8'(dly + 1);
    end else if (fn == 4'hF) begin
      e.cycles = 8'd2; e.pc = exp_pc; e.halted = 1'b1;
    end else begin
      e.cycles = 8'd3; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Issue one instruction from a FETCH cycle, observe until the next FETCH or a stop state
  task automatic run_instr(input logic [31:0] ins, input int dly);
    exp_t e, o;
    int   cyc;
    logic done;
    sb_q.push_back(model(ins, dly));
    o = '0; done = 1'b0; cyc = 1;
    imem_rdata = ins; imem_ack = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_req || halted || error) begin done = 1'b1; break; end
      cyc++;
      if (cyc == 2) begin
        o.flds = {rs, rd, rt, imm9, imm15, alu_op_sel, ms1};
        chk("busy_decode", 80'(busy), 80'(1));
      end
      if (we1) begin o.we_cnt = o.we_cnt + 2'd1; o.ms2_at_we = ms2; end
      if (dmem_req) begin
        o.dreq_cyc = o.dreq_cyc + 8'd1;
        if (dmem_we) o.dwe_seen = 1'b1;
        dmem_ack = (o.dreq_cyc == 8'(dly + 1));
      end else begin
        dmem_ack = 1'b0;
      end
    end
    dmem_ack = 1'b0;
    o.cycles = 8'(cyc); o.pc = imem_addr; o.illegal = illegal; o.halted = halted;
    e = sb_q.pop_front();
    chk("instr_done", 80'(done), 80'(1));
    chk("latency", 80'(o.cycles), 80'(e.cycles));
    chk("fields", 80'(o.flds), 80'(e.flds));
    chk("we1_pulses", 80'(o.we_cnt), 80'(e.we_cnt));
    chk("ms2_at_wb", 80'(o.ms2_at_we), 80'(e.ms2_at_we));
    chk("dmem_we", 80'(o.dwe_seen), 80'(e.dwe_seen));
    chk("dmem_req_cycles", 80'(o.dreq_cyc), 80'(e.dreq_cyc));
    chk("pc_after", 80'(o.pc), 80'(e.pc));
    chk("illegal", 80'(o.illegal), 80'(e.illegal));
    chk("halted", 80'(o.halted), 80'(e.halted));
    exp_pc = e.pc;
    exp_ill = e.illegal;
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({imem_req, dmem_req, dmem_we, we1, ms2, busy, halted, illegal, error,
                imem_addr, rs, rd, rt, imm9, imm15, alu_op_sel, ms1});
  endfunction

  initial begin
    int   n;
    logic seen;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", all_outs(), 80'(0));
    chk("wrap_reset_pc", 80'(w_imem_addr), 80'(16'hFFFF));

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_quiet", 80'({busy, imem_req}), 80'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_req", 80'({imem_req, busy}), 80'(2'b11));
    chk("fetch_pc", 80'(imem_addr), 80'(0));
    exp_pc = 16'h0000; exp_ill = 1'b0;

    run_instr(32'h0000_0000, 0);
    chk("wrap_pc", 80'(w_imem_addr), 80'(16'h0000));
    run_instr(enc(4'h7, TYPE_I, 6'd5, 6'd9, 6'd3, 9'h1A5), 3);
    run_instr(enc(4'h8, TYPE_I, 6'd2, 6'd4, 6'd7, 9'h033), 1);
    run_instr(enc(4'h3, TYPE_R, 6'd1, 6'd0, 6'd2, 9'h100), 0);
    run_instr(enc(4'hA, TYPE_R, 6'd3, 6'd8, 6'd6, 9'h0F0), 0);
    run_instr(enc(4'h6, 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 9'($urandom)), 0);
    run_instr(enc(4'h7, TYPE_I, 6'd63, 6'd62, 6'd61, 9'h1FF), 0);
    run_instr(enc(4'hF, TYPE_R, 6'd0, 6'd0, 6'd0, 9'h000), 0);

    chk("halt_busy", 80'(busy), 80'(0));
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("halt_hold", 80'({halted, imem_req, illegal}), 80'(3'b101));
    chk("halt_pc", 80'(imem_addr), 80'(exp_pc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_flags", 80'({halted, illegal, imem_req}), 80'(3'b001));
    chk("restart_pc", 80'(imem_addr), 80'(0));
    exp_pc = 16'h0000; exp_ill = 1'b0;

    // Load abandoned by reset while its data access is pending
    imem_rdata = enc(4'h7, TYPE_I, 6'd1, 6'd2, 6'd3, 9'h000);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dmem_req;
    end
    chk("mem_reached", 80'(seen), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mem", 80'({dmem_req, busy, imem_req}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Instruction memory never answers
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !error; i++) begin
      if (imem_req) n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 80'(n), 80'(TMO + 1));
    chk("error_state", 80'({error, imem_req, busy}), 80'(3'b100));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("error_sticky", 80'({error, imem_req}), 80'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("reset_clears_error", all_outs(), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Ack arriving on the last allowed wait cycle is still accepted
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (TMO) @(negedge clk);
    chk("last_cycle_no_error", 80'({error, imem_req}), 80'(2'b01));
    exp_pc = 16'h0000; exp_ill = 1'b0;
    run_instr(enc(4'h1, TYPE_R, 6'd4, 6'd5, 6'd6, 9'h055), 0);
    chk("scoreboard_empty", 80'(sb_q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
